fpadd_norm: RTL and testbench

Post-add normalizer for the single-precision floating-point adder. It consumes the 24-bit mantissa sum and carry-out from the 24-bit carry-lookahead adder, together with the pre-add exponent and sign. It normalizes the result iteratively, one bit per cycle, and packs an IEEE-754 single-precision word. It sits directly downstream of the mantissa adder and uses a valid/ready handshake on both sides.

---
 rtl/fpadd_norm.sv | 195 +++++++++++++++++++
 tb/tb_fpadd_norm.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_norm.sv
// fpadd_norm: post-add normalizer for the binary32 adder datapath.
// Takes the mantissa sum/carry from the 24-bit adder plus the pre-add
// exponent and sign. It left-normalizes one bit per cycle and packs an
// IEEE-754 single-precision word behind valid/ready handshakes.
// Optional build macro FPN_ROUND_EN enables guard/round/sticky tracking
// and a round-to-nearest-even stage. Otherwise the result is truncated.
module fpadd_norm #(
    parameter int EW = 8,
    parameter int MW = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MW-1:0]     sum,
    input  logic              cout,
    input  logic              sub,
    input  logic [EW-1:0]     exp_in,
    input  logic              sign_in,
    input  logic [2:0]        grs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+MW-1:0]  result,
    output logic              ovf,
    output logic              unf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd3;
`ifdef FPN_ROUND_EN
    localparam logic [1:0] ST_RND  = 2'd2;
    localparam logic [1:0] ST_POST = ST_RND;
`else
    localparam logic [1:0] ST_POST = ST_DONE;
`endif

    localparam logic [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic [EW-1:0] EXP_TOP  = {{(EW-1){1'b1}}, 1'b0};
    localparam logic [MW-1:0] MANT_ONE = {1'b1, {(MW-1){1'b0}}};

    logic [1:0]    state;
    logic [MW-1:0] mant;
    logic [EW-1:0] e;
    logic          s;
    logic          ovf_r;
    logic          unf_r;
    logic          carry_case;

    assign carry_case = cout & ~sub;

`ifdef FPN_ROUND_EN
    logic          g;
    logic          r;
    logic          st;
    logic          round_up;
    logic [MW:0]   mant_inc;

    // Round-to-nearest-even decision and the incremented mantissa
    always_comb begin
        round_up = g & (r | st | mant[0]);
        mant_inc = {1'b0, mant} + 1'b1;
    end
`else
    logic unused_grs;
    assign unused_grs = ^grs;
`endif

    // Classification at accept, iterative normalization, optional rounding, output hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            mant  <= '0;
            e     <= '0;
            s     <= 1'b0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
`ifdef FPN_ROUND_EN
            g     <= 1'b0;
            r     <= 1'b0;
            st    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        s     <= sign_in;
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
`ifdef FPN_ROUND_EN
                        g     <= grs[2];
                        r     <= grs[1];
                        st    <= grs[0];
`endif
                        if (carry_case) begin
                            mant <= {1'b1, sum[MW-1:1]};
`ifdef FPN_ROUND_EN
                            g    <= sum[0];
                            r    <= grs[2];
                            st   <= |grs[1:0];
`endif
                            if (exp_in == EXP_TOP) begin
                                e     <= '1;
                                mant  <= MANT_ONE;
                                ovf_r <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                e     <= exp_in + 1'b1;
                                state <= ST_POST;
                            end
                        end else if (sum == '0) begin
                            mant  <= '0;
                            e     <= '0;
                            s     <= 1'b0;
                            state <= ST_DONE;
                        end else if (sum[MW-1]) begin
                            mant  <= sum;
                            e     <= exp_in;
                            state <= ST_POST;
                        end else if (exp_in <= EXP_ONE) begin
                            mant  <= sum;
                            e     <= '0;
                            unf_r <= 1'b1;
                            state <= ST_POST;
                        end else begin
                            mant  <= sum;
                            e     <= exp_in;
                            state <= ST_NORM;
                        end
                    end
                end

                ST_NORM: begin
                    if (mant[MW-1]) begin
                        state <= ST_POST;
                    end else if (e == EXP_ONE) begin
                        // Cannot go below the smallest normal exponent: emit as denormal
                        e     <= '0;
                        unf_r <= 1'b1;
                        state <= ST_POST;
                    end else begin
`ifdef FPN_ROUND_EN
                        mant <= {mant[MW-2:0], g};
                        g    <= r;
                        r    <= 1'b0;
`else
                        mant <= {mant[MW-2:0], 1'b0};
`endif
                        e    <= e - 1'b1;
                    end
                end

`ifdef FPN_ROUND_EN
                ST_RND: begin
                    if (round_up) begin
                        if (mant_inc[MW]) begin
                            // All-ones mantissa carries out: renormalize and bump exponent
                            mant <= MANT_ONE;
                            e    <= e + 1'b1;
                            if (e == EXP_TOP) begin
                                ovf_r <= 1'b1;
                            end
                        end else begin
                            mant <= mant_inc[MW-1:0];
                            // Denormal rounding into the hidden bit becomes the smallest normal
                            if (!mant[MW-1] && mant_inc[MW-1]) begin
                                e     <= EXP_ONE;
                                unf_r <= 1'b0;
                            end
                        end
                    end
                    state <= ST_DONE;
                end
`endif

                ST_DONE: begin
                    if (out_ready) begin
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = {s, e, mant[MW-2:0]};
    assign ovf       = ovf_r;
    assign unf       = unf_r;

endmodule

// File: tb/tb_fpadd_norm.sv
// tb_fpadd_norm: directed and pseudo-random vectors for fpadd_norm against a
// behavioural normalizer model, plus hand-computed literal expectations.
module tb_fpadd_norm;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] sum;
    logic        cout;
    logic        sub;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic [2:0]  grs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;

`ifdef FPN_ROUND_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic        o;
        logic        u;
        int          due;
        bit          seen;
    } exp_t;

    exp_t q[$];

    fpadd_norm #(.EW(8), .MW(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .sub       (sub),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .grs       (grs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value semantics of add-normalize(-round), latency in edges from accept
    function automatic void model(input logic [23:0] sm, input logic co, input logic sb,
                                  input logic [7:0] ex, input logic sg, input logic [2:0] gr,
                                  output logic [31:0] res, output logic o, output logic u,
                                  output int lat);
        logic [25:0] x;
        logic        stk;
        logic [23:0] m;
        logic [24:0] m1;
        logic        up;
        int          e;
        int          lz;
        int          sh;
        o   = 1'b0;
        u   = 1'b0;
        lat = 1;
        e   = 0;
`ifdef FPN_ROUND_EN
        x   = {sm, gr[2], gr[1]};
        stk = gr[0];
`else
        x   = {sm, 2'b00};
        stk = 1'b0;
`endif
        if (co && !sb) begin
            if (ex == 8'd254) begin
                res = {sg, 8'hFF, 23'h0};
                o   = 1'b1;
                return;
            end
`ifdef FPN_ROUND_EN
            x   = {1'b1, sm, gr[2]};
            stk = |gr[1:0];
`else
            x   = {1'b1, sm[23:1], 2'b00};
`endif
            e = int'(ex) + 1;
        end else if (sm == 24'h0) begin
            res = 32'h0;
            return;
        end else if (sm[23]) begin
            e = int'(ex);
        end else if (ex <= 8'd1) begin
            e = 0;
            u = 1'b1;
        end else begin
            lz = 0;
            for (int i = 23; i >= 0; i--) begin
                if (sm[i]) break;
                lz++;
            end
            sh  = (lz < int'(ex) - 1) ? lz : int'(ex) - 1;
            x   = x << sh;
            e   = int'(ex) - sh;
            lat = sh + 2;
            if (!x[25]) begin
                e = 0;
                u = 1'b1;
            end
        end
        m = x[25:2];
`ifdef FPN_ROUND_EN
        lat++;
        up = x[1] & (x[0] | stk | m[0]);
        if (up) begin
            m1 = {1'b0, m} + 25'd1;
            if (m1[24]) begin
                m = 24'h800000;
                e++;
                if (e == 255) o = 1'b1;
            end else begin
                m = m1[23:0];
                if (e == 0 && m[23]) begin
                    e = 1;
                    u = 1'b0;
                end
            end
        end
`else
        up = 1'b0;
        m1 = '0;
        if (up || m1[0] || stk) e = e;
`endif
        res = {sg, e[7:0], m[22:0]};
    endfunction

    // Compare process: every cycle the DUT presents a result, check it against the model
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got result 0x%08h with out_valid, expected no output", result);
            end else begin
                chk("result", result, q[0].res);
                chk("ovf", ovf, q[0].o);
                chk("unf", unf, q[0].u);
                chk("in_ready_busy", in_ready, 1'b0);
                if (!q[0].seen) begin
                    chk("latency_cycle", cyc, q[0].due);
                    q[0].seen = 1'b1;
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One transaction; caller is always positioned just after a rising edge
    task automatic send(input logic [23:0] sm, input logic co, input logic sb,
                        input logic [7:0] ex, input logic sg, input logic [2:0] gr,
                        input int hold, input bit use_lit, input logic [31:0] lit_res,
                        input logic lit_o, input logic lit_u, input int lit_lat);
        logic [31:0] mres;
        logic        mo;
        logic        mu;
        int          mlat;
        int          a;
        int          n;
        model(sm, co, sb, ex, sg, gr, mres, mo, mu, mlat);
        if (use_lit) begin
            chk("model_result", mres, lit_res);
            chk("model_flags", {mo, mu}, {lit_o, lit_u});
            chk("model_latency", mlat, lit_lat);
        end
        chk("in_ready_idle", in_ready, 1'b1);
        sum      = sm;
        cout     = co;
        sub      = sb;
        exp_in   = ex;
        sign_in  = sg;
        grs      = gr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = cyc;
        q.push_back('{res: mres, o: mo, u: mu, due: a + mlat - 1, seen: 1'b0});
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got no out_valid after %0d cycles, expected result 0x%08h", n, mres);
            q.delete();
            do_reset();
            return;
        end
        if (use_lit) begin
            chk("dut_result_lit", result, lit_res);
            chk("dut_flags_lit", {ovf, unf}, {lit_o, lit_u});
            chk("dut_latency_lit", n, lit_lat);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 1'b0);
        chk("release_flags", {ovf, unf}, 2'b00);
        chk("release_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [23:0] rs;
        rst       = 1'b0;
        in_valid  = 1'b0;
        sum       = '0;
        cout      = 1'b0;
        sub       = 1'b0;
        exp_in    = '0;
        sign_in   = 1'b0;
        grs       = '0;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {ovf, unf}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send(24'h800000, 0, 0, 8'd127, 0, 3'b000, 0, 1, 32'h3F800000, 0, 0, 1 + RL);
        send(24'h000000, 1, 0, 8'd127, 0, 3'b000, 0, 1, 32'h40000000, 0, 0, 1 + RL);
        send(24'h000000, 1, 0, 8'd254, 0, 3'b000, 0, 1, 32'h7F800000, 1, 0, 1);
        send(24'h000001, 0, 1, 8'd127, 0, 3'b000, 0, 1, 32'h34000000, 0, 0, 25 + RL);
        send(24'h000010, 0, 1, 8'd3,   0, 3'b000, 0, 1, 32'h00000040, 0, 1, 4 + RL);
        send(24'h000000, 0, 1, 8'd127, 1, 3'b000, 0, 1, 32'h00000000, 0, 0, 1);
        send(24'h400000, 0, 0, 8'd1,   1, 3'b000, 0, 1, 32'h80400000, 0, 1, 1 + RL);
        send(24'hC00000, 1, 1, 8'd10,  0, 3'b000, 0, 1, 32'h05400000, 0, 0, 1 + RL);
        send(24'h900000, 0, 0, 8'd130, 1, 3'b000, 5, 1, 32'hC1100000, 0, 0, 1 + RL);
        send(24'h0F0000, 0, 1, 8'd100, 0, 3'b000, 0, 1, 32'h30700000, 0, 0, 6 + RL);
        send(24'h000800, 0, 1, 8'd5,   0, 3'b000, 0, 1, 32'h00008000, 0, 1, 6 + RL);
        send(24'hFFFFFE, 1, 0, 8'd127, 0, 3'b000, 0, 1, 32'h407FFFFF, 0, 0, 1 + RL);
`ifdef FPN_ROUND_EN
        send(24'hFFFFFF, 0, 0, 8'd127, 0, 3'b100, 0, 1, 32'h40000000, 0, 0, 2);
        send(24'h800000, 0, 0, 8'd127, 0, 3'b100, 0, 1, 32'h3F800000, 0, 0, 2);
        send(24'h800001, 0, 0, 8'd127, 0, 3'b100, 0, 1, 32'h3F800002, 0, 0, 2);
`endif

        for (int k = 0; k < 24; k++) begin
            rs = 24'($urandom) >> $urandom_range(0, 23);
            send(rs, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 254)), 1'($urandom),
                 3'($urandom), $urandom_range(0, 2), 0, 32'h0, 0, 0, 0);
        end

        // Reset in the middle of a long normalization drops the transaction
        chk("rst_test_in_ready", in_ready, 1'b1);
        sum      = 24'h000001;
        cout     = 1'b0;
        sub      = 1'b1;
        exp_in   = 8'd127;
        sign_in  = 1'b0;
        grs      = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("norm_busy_in_ready", in_ready, 1'b0);
        chk("norm_busy_out_valid", out_valid, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", result, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_output", out_valid, 1'b0);

        send(24'h800000, 0, 0, 8'd127, 0, 3'b000, 0, 1, 32'h3F800000, 0, 0, 1 + RL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
